fridge_zone_ctrl: RTL

//   Parametrised multi-compartment fridge controller with registered settings.

---
 rtl/fridge_pkg.sv | 24 ++
 rtl/fridge_thermostat.sv | 98 +++++++++
 rtl/fridge_zone_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/fridge_pkg.sv
// Shared types and helpers for the multi-compartment fridge controller.
//   - therm_state_t : per-zone thermostat state (IDLE / COOL / HOLDOFF)
//   - FIELD_TEMP / FIELD_CAP : encodings of the wr_field select
//   - clamp_u : saturating clamp of an unsigned value into [lo, hi]
package fridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOL    = 2'd1,
        ST_HOLDOFF = 2'd2
    } therm_state_t;

    localparam logic FIELD_TEMP = 1'b0;
    localparam logic FIELD_CAP  = 1'b1;

    function automatic logic [31:0] clamp_u(input logic [31:0] v,
                                            input logic [31:0] lo,
                                            input logic [31:0] hi);
        if (v < lo)      return lo;
        else if (v > hi) return hi;
        else             return v;
    endfunction

endpackage

// File: rtl/fridge_thermostat.sv
// One compartment thermostat: IDLE/COOL/HOLDOFF FSM with hysteresis and a
// minimum off-time after each cool phase.
// Optional feature macro: DOOR_ALARM_EN adds a door-open counter and alarm.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   pwr             mains enable; low forces IDLE and clears counters
//   sense_t         measured temperature code
//   set_t           stored setpoint code
//   door / alarm    door open input, door alarm output (DOOR_ALARM_EN only)
//   cool_on         compressor demand, high exactly while in COOL
module fridge_thermostat
    import fridge_pkg::*;
#(
    parameter int TW        = 5,
    parameter int HYST      = 2,
    parameter int MIN_OFF   = 8,
    parameter int ALARM_CYC = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pwr,
    input  logic [TW-1:0] sense_t,
    input  logic [TW-1:0] set_t,
`ifdef DOOR_ALARM_EN
    input  logic          door,
    output logic          alarm,
`endif
    output logic          cool_on
);

    localparam int CNT_W = (MIN_OFF > 1) ? $clog2(MIN_OFF) : 1;

    therm_state_t     state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;

    // One extra bit so set_t + HYST cannot wrap near the top of the code range.
    logic [TW:0] sense_x, set_x, thr_x;
    assign sense_x = {1'b0, sense_t};
    assign set_x   = {1'b0, set_t};
    assign thr_x   = set_x + (TW+1)'(HYST);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        if (!pwr) begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (sense_x > thr_x) state_nx = ST_COOL;
                end
                ST_COOL: begin
                    if (sense_x <= set_x) begin
                        state_nx = ST_HOLDOFF;
                        cnt_nx   = CNT_W'(MIN_OFF - 1);
                    end
                end
                ST_HOLDOFF: begin
                    // sense_t is deliberately ignored here: no re-entry until the off-time expires.
                    if (cnt == '0) state_nx = ST_IDLE;
                    else           cnt_nx   = cnt - CNT_W'(1);
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    assign cool_on = (state == ST_COOL);

`ifdef DOOR_ALARM_EN
    localparam int DW = $clog2(ALARM_CYC + 1);

    logic [DW-1:0] door_cnt;

    // Saturating open-time counter; any closed-door or power-off cycle restarts it.
    always_ff @(posedge clk) begin
        if (rst || !pwr || !door) begin
            door_cnt <= '0;
        end else if (door_cnt != DW'(ALARM_CYC)) begin
            door_cnt <= door_cnt + DW'(1);
        end
    end

    assign alarm = (door_cnt == DW'(ALARM_CYC));
`endif

endmodule

// File: rtl/fridge_zone_ctrl.sv
// Multi-compartment fridge controller: registered setpoint/capacity bank with
// write decode, plus one fridge_thermostat per compartment.
// Optional feature macro: DOOR_ALARM_EN adds per-zone door/alarm ports.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   pwr          mains enable; low blocks writes and idles every thermostat
//   wr_valid     write request; wr_ready = pwr && !rst
//   wr_field     FIELD_TEMP (setpoint) or FIELD_CAP (capacity)
//   wr_zone      target compartment; out-of-range zones are accepted and dropped
//   wr_data      write value; setpoints are clamped to [T_MIN, T_MAX]
//   sense_t      measured temperatures, zone k at [k*TW +: TW]
//   set_t, cap   stored setpoints and capacities
//   door, alarm  per-zone door input and alarm output (DOOR_ALARM_EN only)
//   cool_on      per-zone compressor demand
module fridge_zone_ctrl
    import fridge_pkg::*;
#(
    parameter int N_ZONE    = 2,
    parameter int TW        = 5,
    parameter int CW        = 2,
    parameter int T_MIN     = 0,
    parameter int T_MAX     = 31,
    parameter int T_DEF     = 16,
    parameter int HYST      = 2,
    parameter int MIN_OFF   = 8,
    parameter int ALARM_CYC = 64,
    localparam int ZW       = (N_ZONE > 1) ? $clog2(N_ZONE) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwr,
    input  logic                 wr_valid,
    output logic                 wr_ready,
    input  logic                 wr_field,
    input  logic [ZW-1:0]        wr_zone,
    input  logic [TW-1:0]        wr_data,
    input  logic [N_ZONE*TW-1:0] sense_t,
    output logic [N_ZONE*TW-1:0] set_t,
    output logic [N_ZONE*CW-1:0] cap,
`ifdef DOOR_ALARM_EN
    input  logic [N_ZONE-1:0]    door,
    output logic [N_ZONE-1:0]    alarm,
`endif
    output logic [N_ZONE-1:0]    cool_on
);

    logic [TW-1:0] set_q [N_ZONE];
    logic [CW-1:0] cap_q [N_ZONE];
    logic          wr_fire;
    logic          zone_ok;
    logic [TW-1:0] set_wr;

    assign wr_ready = pwr && !rst;
    assign wr_fire  = wr_valid && wr_ready;
    assign zone_ok  = int'(wr_zone) < N_ZONE;
    assign set_wr   = TW'(clamp_u(32'(wr_data), 32'(T_MIN), 32'(T_MAX)));

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_ZONE; k++) begin
            if (rst) begin
                set_q[k] <= TW'(T_DEF);
                cap_q[k] <= '0;
            end else if (wr_fire && zone_ok && (int'(wr_zone) == k)) begin
                if (wr_field == FIELD_TEMP) set_q[k] <= set_wr;
                else                        cap_q[k] <= wr_data[CW-1:0];
            end
        end
    end

    for (genvar g = 0; g < N_ZONE; g++) begin : g_zone
        assign set_t[g*TW +: TW] = set_q[g];
        assign cap[g*CW +: CW]   = cap_q[g];

        fridge_thermostat #(
            .TW        (TW),
            .HYST      (HYST),
            .MIN_OFF   (MIN_OFF),
            .ALARM_CYC (ALARM_CYC)
        ) u_therm (
            .clk     (clk),
            .rst     (rst),
            .pwr     (pwr),
            .sense_t (sense_t[g*TW +: TW]),
            .set_t   (set_q[g]),
`ifdef DOOR_ALARM_EN
            .door    (door[g]),
            .alarm   (alarm[g]),
`endif
            .cool_on (cool_on[g])
        );
    end

endmodule
